// File: rtl/water_fill_arbiter.sv
// Round-robin arbiter sharing one mains inlet valve between N machine fill controllers.
// Optional statistics ports (grant_count, timeout_count) enabled by WATER_FILL_STATS_EN.
module water_fill_arbiter #(
   parameter int N        = 4,
   parameter int MAX_FILL = 200,
   parameter int GAP      = 3,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         fill_req,
   input  logic [N-1:0]         filled,
   output logic [N-1:0]         grant,
   output logic                 main_valve_on,
   output logic [N-1:0]         fill_timeout,
   output logic [$clog2(N)-1:0] owner,
`ifdef WATER_FILL_STATS_EN
   output logic [15:0]          grant_count,
   output logic [7:0]           timeout_count,
`endif
   output logic                 busy
);

   localparam int          OW = $clog2(N);
   localparam int unsigned NU = N;

   typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic             valve_q, valve_d;
   logic [N-1:0]     timeout_q, timeout_d;
   logic [N-1:0]     lockout_q, lockout_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      gcnt_q, gcnt_d;
   logic [7:0]       tcnt_q, tcnt_d;

   logic [N-1:0]     eligible;
   logic             found;
   logic [OW-1:0]    sel;
   int unsigned      idx;
   logic             rel_normal;
   logic             rel_timeout;

   always_comb begin
      eligible = fill_req & ~filled & ~lockout_q;
      found    = 1'b0;
      sel      = '0;
      idx      = 0;
      for (int unsigned k = 0; k < NU; k++) begin
         idx = (32'(ptr_q) + k) % NU;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            sel   = OW'(idx);
         end
      end

      rel_normal  = !fill_req[owner_q] || filled[owner_q];
      rel_timeout = (cnt_q == CNT_W'(MAX_FILL - 1));

      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = '0;
      lockout_d = lockout_q & fill_req;
      gcnt_d    = gcnt_q;
      tcnt_d    = tcnt_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               grant_d = N'(1) << sel;
               owner_d = sel;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (rel_normal || rel_timeout) begin
               state_d = SETTLE;
               grant_d = '0;
               cnt_d   = '0;
               ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
               gcnt_d  = (gcnt_q == '1) ? gcnt_q : gcnt_q + 16'd1;
               // a request that is withdrawn or satisfied on the last cycle is not a timeout
               if (!rel_normal) begin
                  timeout_d[owner_q] = 1'b1;
                  lockout_d[owner_q] = 1'b1;
                  tcnt_d             = (tcnt_q == '1) ? tcnt_q : tcnt_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_W'(GAP - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      valve_d = |grant_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         valve_q   <= 1'b0;
         timeout_q <= '0;
         lockout_q <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gcnt_q    <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valve_q   <= valve_d;
         timeout_q <= timeout_d;
         lockout_q <= lockout_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gcnt_q    <= gcnt_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign grant         = grant_q;
   assign main_valve_on = valve_q;
   assign fill_timeout  = timeout_q;
   assign owner         = owner_q;
   assign busy          = (state_q != IDLE);

`ifdef WATER_FILL_STATS_EN
   assign grant_count   = gcnt_q;
   assign timeout_count = tcnt_q;
`else
   logic stats_unused;
   assign stats_unused = ^{gcnt_q, tcnt_q};
`endif

endmodule

// File: tb/tb_water_fill_arbiter.sv
// Bench for water_fill_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a cycle-count based behavioural model of the arbitration rules.
module tb_water_fill_arbiter;

   localparam int N        = 4;
   localparam int MAX_FILL = 200;
   localparam int GAP      = 3;
   localparam int OW       = $clog2(N);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  fill_req = '0;
   logic [N-1:0]  filled = '0;
   logic [N-1:0]  grant;
   logic          main_valve_on;
   logic [N-1:0]  fill_timeout;
   logic [OW-1:0] owner;
   logic          busy;
`ifdef WATER_FILL_STATS_EN
   logic [15:0]   grant_count;
   logic [7:0]    timeout_count;
`endif

   water_fill_arbiter #(.N(N), .MAX_FILL(MAX_FILL), .GAP(GAP), .CNT_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .fill_req(fill_req),
      .filled(filled),
      .grant(grant),
      .main_valve_on(main_valve_on),
      .fill_timeout(fill_timeout),
      .owner(owner),
`ifdef WATER_FILL_STATS_EN
      .grant_count(grant_count),
      .timeout_count(timeout_count),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: who holds the valve, for how many cycles, how many settle cycles remain.
   int           m_own = -1;
   int           m_last = 0;
   int           m_held = 0;
   int           m_settle = 0;
   int           m_ptr = 0;
   bit [N-1:0]   m_lock = '0;
   bit [N-1:0]   m_to = '0;
   int           m_gc = 0;
   int           m_tc = 0;
   bit           model_valid = 1'b0;
   bit [N-1:0]   s_req, s_fl, s_lock;
   int           s_idx;

   always @(posedge clk) begin
      if (reset) begin
         m_own = -1; m_last = 0; m_held = 0; m_settle = 0; m_ptr = 0;
         m_lock = '0; m_to = '0; m_gc = 0; m_tc = 0;
         model_valid = 1'b1;
      end else begin
         s_req  = fill_req;
         s_fl   = filled;
         s_lock = m_lock;
         m_to   = '0;
         if (m_own >= 0) begin
            if (!s_req[m_own] || s_fl[m_own] || m_held == MAX_FILL) begin
               if (s_req[m_own] && !s_fl[m_own]) begin
                  m_to[m_own] = 1'b1;
                  if (m_tc < 255) m_tc++;
               end
               if (m_gc < 65535) m_gc++;
               m_ptr    = (m_own + 1) % N;
               m_own    = -1;
               m_settle = GAP;
            end else begin
               m_held++;
            end
         end else if (m_settle > 0) begin
            m_settle--;
         end else begin
            for (int k = 0; k < N; k++) begin
               s_idx = (m_ptr + k) % N;
               if (m_own < 0 && s_req[s_idx] && !s_fl[s_idx] && !s_lock[s_idx]) begin
                  m_own  = s_idx;
                  m_last = s_idx;
                  m_held = 1;
               end
            end
         end
         m_lock = (s_lock & s_req) | m_to;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("grant", grant, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
         chk("valve", main_valve_on, (m_own >= 0) ? 1 : 0);
         chk("valve_or", main_valve_on, |grant);
         chk("onehot", $onehot0(grant), 1);
         chk("fill_timeout", fill_timeout, m_to);
         chk("owner", owner, m_last);
         chk("busy", busy, (m_own >= 0 || m_settle > 0) ? 1 : 0);
`ifdef WATER_FILL_STATS_EN
         chk("grant_count", grant_count, m_gc);
         chk("timeout_count", timeout_count, m_tc);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; fill_req = '0; filled = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic wait_grant(input int limit, output int n);
      n = 0;
      while (grant == '0 && n < limit) begin
         tick();
         n++;
      end
      chk("grant_wait_bound", (grant != '0), 1);
   endtask

   int n, len, gi;
   int rr_exp [4] = '{0, 1, 3, 0};

   initial begin
      // reset state
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_valve", main_valve_on, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_to", fill_timeout, 0);

      // single request
      fill_req = 4'b0100;
      tick();
      chk("t1_grant", grant, 4'b0100);
      chk("t1_valve", main_valve_on, 1);
      chk("t1_owner", owner, 2);
      repeat (10) tick();
      filled = 4'b0100;
      tick();
      chk("t1_release", grant, 0);
      chk("t1_valve_off", main_valve_on, 0);
      chk("t1_busy_settle", busy, 1);
      repeat (2) tick();
      chk("t1_busy_last", busy, 1);
      tick();
      chk("t1_busy_idle", busy, 0);
      fill_req = '0; filled = '0;

      // round-robin order and settle gap
      do_reset();
      fill_req = 4'b1011;
      for (int g = 0; g < 4; g++) begin
         wait_grant(20, n);
         if (g > 0) chk("rr_gap", n, GAP + 1);
         gi = 0;
         for (int i = 0; i < N; i++) if (grant[i]) gi = i;
         chk("rr_order", gi, rr_exp[g]);
         repeat (4) tick();
         filled = grant;
         tick();
         chk("rr_release", grant, 0);
         filled = '0;
      end
      fill_req = '0;

      // timeout and lockout
      do_reset();
      fill_req = 4'b0010;
      tick();
      len = 1;
      while (grant == 4'b0010 && len < 300) begin
         tick();
         if (grant == 4'b0010) len++;
      end
      chk("to_len", len, MAX_FILL);
      chk("to_pulse", fill_timeout, 4'b0010);
      tick();
      chk("to_pulse_end", fill_timeout, 0);
      repeat (20) tick();
      chk("to_lockout", grant, 0);
      fill_req = '0;
      tick();
      fill_req = 4'b0010;
      wait_grant(20, n);
      chk("to_regrant_lat", n, 1);
      chk("to_regrant", grant, 4'b0010);
      fill_req = '0;

      // request dropped mid-grant
      do_reset();
      fill_req = 4'b1000;
      tick();
      repeat (5) tick();
      fill_req = '0;
      tick();
      chk("drop_release", grant, 0);
      chk("drop_no_to", fill_timeout, 0);
      repeat (3) tick();
      fill_req = 4'b1001;
      wait_grant(20, n);
      chk("drop_ptr_wrap", grant, 4'b0001);
      fill_req = '0;

      // filled on the final allowed cycle
      do_reset();
      fill_req = 4'b0001;
      tick();
      repeat (MAX_FILL - 1) tick();
      chk("last_still_granted", grant, 4'b0001);
      filled = 4'b0001;
      tick();
      chk("last_release", grant, 0);
      chk("last_no_to", fill_timeout, 0);
      filled = '0;
      wait_grant(20, n);
      chk("last_no_lockout", n, GAP + 1);
      fill_req = '0;

      // reset mid-grant
      do_reset();
      fill_req = 4'b0100;
      tick();
      repeat (49) tick();
      reset = 1'b1;
      tick();
      chk("rstg_grant", grant, 0);
      chk("rstg_valve", main_valve_on, 0);
      chk("rstg_busy", busy, 0);
`ifdef WATER_FILL_STATS_EN
      chk("rstg_gcount", grant_count, 0);
`endif
      reset = 1'b0; fill_req = '0;

      // randomized traffic
      for (int c = 0; c < 6000; c++) begin
         reset = ($urandom_range(0, 1499) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 19) == 0) fill_req[i] = ~fill_req[i];
            if ($urandom_range(0, 39) == 0) filled[i] = ~filled[i];
         end
         tick();
      end
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/water_fill_arbiter.md
Name: water_fill_arbiter

Overview:
- Shares one mains water inlet valve between N washing-machine controllers in a laundromat cluster.
- Each machine raises fill_req while its controller is in its fill state.
- The arbiter grants the inlet to one machine at a time, in round-robin order, with a per-grant fill timeout and a valve settle gap between grants.
- Sits between the per-machine controllers (fill request, filled sensor) and the physical main valve driver.

Parameters:
- N, 4, number of requesting machines (2..8)
- MAX_FILL, 200, maximum grant length in clk cycles before forced release
- GAP, 3, settle cycles with valve closed between consecutive grants (>=1)
- CNT_W, 8, width of fill counter; must satisfy 2^CNT_W > MAX_FILL

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fill_req  in  N  per-machine fill request, level
- filled  in  N  per-machine water-level-reached sensor, level
- grant  out  N  one-hot (or zero) inlet grant, registered
- main_valve_on  out  1  drives shared inlet valve, registered
- fill_timeout  out  N  one-cycle pulse to the machine whose grant hit MAX_FILL
- owner  out  $clog2(N)  index of current/last grantee
- busy  out  1  high in GRANT or SETTLE

Behaviour:
- Reset values (all outputs):
  - grant=0, main_valve_on=0, fill_timeout=0, owner=0, busy=0.
  - Internally: state=IDLE, counter=0, lockout=0, round-robin pointer=0 (search starts at index 0).
- Eligible requester i: fill_req[i]=1 AND filled[i]=0 AND lockout[i]=0.
- IDLE:
  - If any requester is eligible, pick the first eligible index searching upward from pointer, wrapping mod N.
  - Next cycle: state=GRANT, grant[sel]=1, main_valve_on=1, owner=sel, counter=0, busy=1.
  - Latency from request sampled in IDLE to grant visible: 1 cycle.
- GRANT: counter increments each cycle. Release conditions, checked in this priority order:
  1. fill_req[owner]=0 or filled[owner]=1 -> normal release.
  2. counter==MAX_FILL-1 -> timeout release; fill_timeout[owner]=1 for exactly the next cycle; lockout[owner] set.
- On release:
  - Next cycle grant=0, main_valve_on=0, state=SETTLE, counter=0.
  - pointer=owner+1 (mod N).
  - Grant length is never more than MAX_FILL cycles.
- SETTLE:
  - Valve closed, grant=0, busy=1 for GAP cycles, then IDLE (busy=0).
  - A new grant appears no earlier than GAP+1 cycles after the valve closes.
- lockout[i]:
  - Cleared in any cycle where fill_req[i]=0.
  - A timed-out machine must drop its request before it is eligible again.
- Simultaneous requests: only the round-robin order decides. There is no fixed priority. Starvation-free: each eligible requester waits at most N-1 grants.
- New requests arriving during GRANT or SETTLE are held by level only. No queueing. A requester that drops its request before being selected is forgotten.
- filled[owner] and timeout in the same cycle: normal release wins. No timeout pulse, no lockout.
- Reset asserted mid-grant: valve closes on the next clock edge, all state returns to reset values, and any pending timeout pulse is suppressed.
- grant is never multi-hot. main_valve_on == |grant at all times.

Optional Feature:
- Macro: WATER_FILL_STATS_EN.
- Defined:
  - Adds output port grant_count (16 bits): a saturating count of completed grants. Increments once per release, both normal and timeout; holds at 16'hFFFF.
  - Adds output port timeout_count (8 bits): a saturating count of timeout releases.
  - Both counters reset to 0.
- Undefined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Single request: N=4, fill_req=4'b0100 in IDLE; filled[2] rises 10 cycles after grant.
  - Required: grant=4'b0100 and valve=1 one cycle after the request; both drop 1 cycle after filled; busy low after 3 SETTLE cycles.
- Round-robin: fill_req=4'b1011 held, each grantee's filled pulsed 5 cycles into its grant.
  - Required grant order: 0,1,3,0.
  - Required timing: each new grant starts exactly GAP+1=4 cycles after the previous valve-off.
- Timeout: fill_req[1]=1, filled[1] held 0.
  - Required: grant[1] lasts exactly 200 cycles, then fill_timeout=4'b0010 for 1 cycle.
  - Required: req 1 is not regranted until fill_req[1] drops for ≥1 cycle and reasserts.
- Request drop: fill_req[3] drops mid-grant.
  - Required: grant released next cycle, no timeout pulse, pointer=0.
- Filled on the final cycle: filled asserted on cycle MAX_FILL-1.
  - Required: normal release, fill_timeout stays 0.
- Reset mid-grant: reset asserted 50 cycles into a grant.
  - Required: grant=0, valve=0, busy=0 next cycle; with WATER_FILL_STATS_EN defined, grant_count=0.
